// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 (50 MHz) timing defaults and small helpers.
// Used by vga_timing_gen and by any picture source that needs to know the raster geometry.
package vga_timing_pkg;

  // Pixel clock divider: 50 MHz / 2 = 25 MHz, close enough to the nominal 25.175 MHz.
  localparam int DEF_CLK_DIV = 2;

  // Horizontal geometry in pixels.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Vertical geometry in lines.
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Both syncs are active-low for this mode.
  localparam logic DEF_H_POL = 1'b0;
  localparam logic DEF_V_POL = 1'b0;

  // Counter and colour widths.
  localparam int DEF_HW    = 11;
  localparam int DEF_VW    = 10;
  localparam int DEF_RGB_W = 1;

  // Number of vertical colour bars in the test pattern.
  localparam int BAR_COUNT = 8;

  // Full line length including blanking.
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Full frame height including blanking.
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_ce_div.sv
// vga_ce_div: divides clk50 into a one-cycle pixel enable.
// tick is the combinational "advance now" signal used by the raster counters in the same edge;
// pix_ce is its registered copy so it lines up with the counter values it describes.
module vga_ce_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk50,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic pix_ce
);

  localparam int CW = counter_width(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  // The divider wraps on the same edge that the raster counters step, so tick is combinational.
  assign tick = en && !rst && (count == DIV_LAST);

  // Divider count and registered pixel enable; en low freezes the count and silences pix_ce.
  always_ff @(posedge clk50) begin
    if (rst) begin
      count  <= '0;
      pix_ce <= 1'b0;
    end else begin
      pix_ce <= tick;
      if (en) begin
        if (count == DIV_LAST) begin
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces pixel/line counters, sync pulses, data enable, line/frame strobes and an optional test pattern.
// Every output is registered and describes the hst/vst held in the same cycle.
// Optional feature: define VGA_TESTPAT_EN to drive 8 vertical colour bars on rgb; otherwise rgb is 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic H_POL    = DEF_H_POL,
  parameter logic V_POL    = DEF_V_POL,
  parameter int   HW       = DEF_HW,
  parameter int   VW       = DEF_VW,
  parameter int   RGB_W    = DEF_RGB_W
) (
  input  logic               clk50,
  input  logic               rst,
  input  logic               en,
  output logic               pix_ce,
  output logic [HW-1:0]      hst,
  output logic [VW-1:0]      vst,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [3*RGB_W-1:0] rgb
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Boundaries as full-width constants so every comparison is done at counter width.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Refuse to elaborate configurations the counters cannot represent.
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_TOTAL > 2**HW) begin : g_bad_hw
    $error("vga_timing_gen: H_TOTAL does not fit in HW bits");
  end
  if (V_TOTAL > 2**VW) begin : g_bad_vw
    $error("vga_timing_gen: V_TOTAL does not fit in VW bits");
  end

  logic tick;

  vga_ce_div #(
    .CLK_DIV(CLK_DIV)
  ) u_ce_div (
    .clk50 (clk50),
    .rst   (rst),
    .en    (en),
    .tick  (tick),
    .pix_ce(pix_ce)
  );

  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          hs_next;
  logic          vs_next;
  logic          de_next;

  // Position the raster moves to on the next pixel, plus the outputs that position implies.
  always_comb begin
    h_next = hst;
    v_next = vst;
    if (hst == H_LAST) begin
      h_next = '0;
      if (vst == V_LAST) begin
        v_next = '0;
      end else begin
        v_next = vst + 1'b1;
      end
    end else begin
      h_next = hst + 1'b1;
    end
    de_next = (h_next < H_ACT) && (v_next < V_ACT);
    hs_next = ((h_next >= HS_BEGIN) && (h_next < HS_END)) ? H_POL : ~H_POL;
    vs_next = ((v_next >= VS_BEGIN) && (v_next < VS_END)) ? V_POL : ~V_POL;
  end

  // Raster counters and timing outputs; they only move on a pixel tick, strobes clear otherwise.
  always_ff @(posedge clk50) begin
    if (rst) begin
      hst         <= H_LAST;
      vst         <= V_LAST;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick) begin
      hst         <= h_next;
      vst         <= v_next;
      hsync       <= hs_next;
      vsync       <= vs_next;
      de          <= de_next;
      line_start  <= (h_next == '0);
      frame_start <= (h_next == '0) && (v_next == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TESTPAT_EN

  // Bars are H_ACTIVE/8 pixels wide; a zero width would stall the bar counter, so clamp to 1.
  localparam int BAR_W   = (H_ACTIVE / BAR_COUNT > 0) ? (H_ACTIVE / BAR_COUNT) : 1;
  localparam int BCW     = counter_width(BAR_W);
  localparam logic [BCW-1:0] BAR_CNT_LAST = BCW'(BAR_W - 1);
  localparam logic [2:0]     BAR_MAX      = 3'(BAR_COUNT - 1);

  logic [2:0]         bar;
  logic [BCW-1:0]     bar_cnt;
  logic [2:0]         bar_next;
  logic [BCW-1:0]     bar_cnt_next;
  logic [3*RGB_W-1:0] colour_next;

  // Bar index for the next pixel: restart at the line start, step every BAR_W pixels, stop at the last bar.
  always_comb begin
    bar_next     = bar;
    bar_cnt_next = bar_cnt;
    if (h_next == '0) begin
      bar_next     = '0;
      bar_cnt_next = '0;
    end else if (bar_cnt == BAR_CNT_LAST) begin
      bar_cnt_next = '0;
      if (bar != BAR_MAX) begin
        bar_next = bar + 1'b1;
      end
    end else begin
      bar_cnt_next = bar_cnt + 1'b1;
    end
    colour_next = {{RGB_W{~bar_next[2]}}, {RGB_W{~bar_next[1]}}, {RGB_W{~bar_next[0]}}};
  end

  // Bar state and colour output, registered with the counters so rgb stays aligned with de.
  always_ff @(posedge clk50) begin
    if (rst) begin
      bar     <= '0;
      bar_cnt <= '0;
      rgb     <= '0;
    end else if (tick) begin
      bar     <= bar_next;
      bar_cnt <= bar_cnt_next;
      rgb     <= de_next ? colour_next : '0;
    end
  end

`else

  assign rgb = '0;

`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen using a reduced raster so whole frames fit
// in a short run. Works with or without VGA_TESTPAT_EN.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int   CLK_DIV  = 2;
  localparam int   H_ACTIVE = 16;
  localparam int   H_FP     = 2;
  localparam int   H_SYNC   = 3;
  localparam int   H_BP     = 3;
  localparam int   V_ACTIVE = 8;
  localparam int   V_FP     = 2;
  localparam int   V_SYNC   = 2;
  localparam int   V_BP     = 2;
  localparam logic H_POL    = 1'b0;
  localparam logic V_POL    = 1'b1;
  localparam int   HW       = 11;
  localparam int   VW       = 10;
  localparam int   RGB_W    = 1;
  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   BAR_W    = H_ACTIVE / 8;

  typedef struct {
    logic               pix_ce;
    logic [HW-1:0]      hst;
    logic [VW-1:0]      vst;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic               line_start;
    logic               frame_start;
    logic [3*RGB_W-1:0] rgb;
  } exp_t;

  logic               clk50;
  logic               rst;
  logic               en;
  logic               pix_ce;
  logic [HW-1:0]      hst;
  logic [VW-1:0]      vst;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               line_start;
  logic               frame_start;
  logic [3*RGB_W-1:0] rgb;

  exp_t sb[$];
  exp_t cur;
  int   m_div, m_h, m_v;
  int   total, bad;
  int   cyc, last_ls, last_fs, n_line_per, n_frame_per;
  bit   measure;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(H_POL), .V_POL(V_POL), .HW(HW), .VW(VW), .RGB_W(RGB_W)
  ) dut (
    .clk50      (clk50),
    .rst        (rst),
    .en         (en),
    .pix_ce     (pix_ce),
    .hst        (hst),
    .vst        (vst),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .line_start (line_start),
    .frame_start(frame_start),
    .rgb        (rgb)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Outputs the raster should show while parked at position (h, v), strobes excluded.
  function automatic exp_t at_pos(input int h, input int v);
    exp_t e;
    int   b;
    e.pix_ce      = 1'b0;
    e.line_start  = 1'b0;
    e.frame_start = 1'b0;
    e.hst         = HW'(h);
    e.vst         = VW'(v);
    e.de          = (h < H_ACTIVE) && (v < V_ACTIVE);
    e.hsync       = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? H_POL : !H_POL;
    e.vsync       = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? V_POL : !V_POL;
    e.rgb         = '0;
`ifdef VGA_TESTPAT_EN
    if (e.de) begin
      b = h / BAR_W;
      if (b > 7) b = 7;
      e.rgb = 3'(7 - b);
    end
`else
    b = 0;
`endif
    return e;
  endfunction

  // Pop the expectation for this cycle and compare every output field.
  task automatic popAndCompare();
    exp_t e;
    cyc++;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    checkOutput("pix_ce", pix_ce, e.pix_ce);
    checkOutput("hst", hst, e.hst);
    checkOutput("vst", vst, e.vst);
    checkOutput("hsync", hsync, e.hsync);
    checkOutput("vsync", vsync, e.vsync);
    checkOutput("de", de, e.de);
    checkOutput("line_start", line_start, e.line_start);
    checkOutput("frame_start", frame_start, e.frame_start);
    checkOutput("rgb", rgb, e.rgb);
    if (measure && line_start === 1'b1) begin
      if (last_ls >= 0) begin
        checkOutput("line_period", cyc - last_ls, H_TOTAL * CLK_DIV);
        n_line_per++;
      end
      last_ls = cyc;
    end
    if (measure && frame_start === 1'b1) begin
      if (last_fs >= 0) begin
        checkOutput("frame_period", cyc - last_fs, H_TOTAL * V_TOTAL * CLK_DIV);
        n_frame_per++;
      end
      last_fs = cyc;
    end
  endtask

  // Drive one clk50 cycle of stimulus, advance the reference model and queue its expectation.
  task automatic applyStimulus(input logic r, input logic e);
    @(negedge clk50);
    rst = r;
    en  = e;
    if (r) begin
      m_div = 0;
      m_h   = H_TOTAL - 1;
      m_v   = V_TOTAL - 1;
      cur   = at_pos(m_h, m_v);
    end else if (e && m_div == CLK_DIV - 1) begin
      m_div = 0;
      m_h++;
      if (m_h == H_TOTAL) begin
        m_h = 0;
        m_v++;
        if (m_v == V_TOTAL) m_v = 0;
      end
      cur             = at_pos(m_h, m_v);
      cur.pix_ce      = 1'b1;
      cur.line_start  = (m_h == 0);
      cur.frame_start = (m_h == 0) && (m_v == 0);
    end else begin
      if (e) m_div++;
      cur.pix_ce      = 1'b0;
      cur.line_start  = 1'b0;
      cur.frame_start = 1'b0;
    end
    sb.push_back(cur);
    @(posedge clk50);
    #1;
    popAndCompare();
  endtask

  initial begin
    int  n;
    bit  found;
    rst = 1'b1;
    en  = 1'b1;
    total = 0; bad = 0; cyc = 0;
    last_ls = -1; last_fs = -1; n_line_per = 0; n_frame_per = 0;
    measure = 1'b0;
    m_div = 0; m_h = H_TOTAL - 1; m_v = V_TOTAL - 1;
    cur = at_pos(m_h, m_v);

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);

    $display("[TB] release reset, first pixel latency");
    measure = 1'b1;
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b1);
      n++;
    end while (pix_ce !== 1'b1 && n < 10);
    checkOutput("first_ce_latency", n, CLK_DIV);
    checkOutput("first_frame_start", frame_start, 1);
    checkOutput("first_hst", hst, 0);

    $display("[TB] two frames");
    for (int i = 0; i < 2 * H_TOTAL * V_TOTAL * CLK_DIV + 4; i++) applyStimulus(1'b0, 1'b1);
    measure = 1'b0;
    checkOutput("line_periods_seen", n_line_per >= 2 * V_TOTAL - 1, 1);
    checkOutput("frame_periods_seen", n_frame_per >= 2, 1);

    $display("[TB] enable hold mid-line");
    found = 1'b0;
    for (int i = 0; i < 4 * H_TOTAL * CLK_DIV && !found; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (cur.pix_ce && m_h == 10) found = 1'b1;
    end
    checkOutput("reach_h10", found, 1);
    for (int i = 0; i < 37; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("hold_hst", hst, 10);
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b1);
      n++;
    end while (pix_ce !== 1'b1 && n < CLK_DIV + 2);
    checkOutput("resume_ce_seen", pix_ce, 1);
    checkOutput("resume_hst", hst, 11);

    $display("[TB] reset mid-frame");
    found = 1'b0;
    for (int i = 0; i < 2 * H_TOTAL * V_TOTAL * CLK_DIV && !found; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (cur.pix_ce && m_v == 5 && m_h == 7) found = 1'b1;
    end
    checkOutput("reach_v5_h7", found, 1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midrst_hst", hst, H_TOTAL - 1);
    checkOutput("midrst_vst", vst, V_TOTAL - 1);
    checkOutput("midrst_de", de, 0);
    checkOutput("midrst_rgb", rgb, 0);

    $display("[TB] random enable");
    for (int i = 0; i < 600; i++) applyStimulus(1'b0, ($urandom_range(0, 3) != 0));

    $display("[TB] reset with enable low");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("post_rst_frame_start", frame_start, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
